// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-select and register-index constants
package wb_pkg;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC4 = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/rf_32x32.sv
// rtl/rf_32x32.sv - 32x32 register array, two async read ports, registered debug port
module rf_32x32
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  reg_idx_t        waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_idx_t        raddr1,
  input  reg_idx_t        raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  reg_idx_t        dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic [XLEN-1:0] dbg_data_q;
  logic [XLEN-1:0] dbg_data_d;

  // Entry 0 is never written, and every read port also masks it to zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != REG_X0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_comb begin
    dbg_data_d = '0;
    if (dbg_addr != REG_X0) begin
      dbg_data_d = regs_q[dbg_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign rdata1   = (raddr1 == REG_X0) ? '0 : regs_q[raddr1];
  assign rdata2   = (raddr2 == REG_X0) ? '0 : regs_q[raddr2];
  assign dbg_data = dbg_data_q;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback mux, register file with write-through bypass, retired counter
module wb_regfile
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wb_valid,
  input  logic             wb_regwrite,
  input  logic [1:0]       wb_wdsel,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_alu_result,
  input  logic [XLEN-1:0]  wb_mem_data,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  output logic [XLEN-1:0]  id_rd1,
  output logic [XLEN-1:0]  id_rd2,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [XLEN-1:0]  wb_wdata,
  output logic             wb_we,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  rf_rd1;
  logic [XLEN-1:0]  rf_rd2;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  always_comb begin
    wb_wdata = '0;
    case (wb_wdsel)
      WDSEL_ALU: wb_wdata = wb_alu_result;
      WDSEL_MEM: wb_wdata = wb_mem_data;
      WDSEL_PC4: wb_wdata = wb_pc + XLEN'(4);
      default:   wb_wdata = '0;
    endcase
  end

  assign wb_we = wb_valid & wb_regwrite & (wb_rd != REG_X0);

  rf_32x32 #(
    .XLEN(XLEN)
  ) u_rf (
    .clk      (clk),
    .rstn     (rstn),
    .we       (wb_we),
    .waddr    (wb_rd),
    .wdata    (wb_wdata),
    .raddr1   (id_rs1),
    .raddr2   (id_rs2),
    .rdata1   (rf_rd1),
    .rdata2   (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Same-cycle bypass lets ID see the value WB is about to commit this edge.
  always_comb begin
    id_rd1 = rf_rd1;
    id_rd2 = rf_rd2;
    if (id_rs1 == REG_X0) begin
      id_rd1 = '0;
    end else if (wb_we && (id_rs1 == wb_rd)) begin
      id_rd1 = wb_wdata;
    end
    if (id_rs2 == REG_X0) begin
      id_rd2 = '0;
    end else if (wb_we && (id_rs2 == wb_rd)) begin
      id_rd2 = wb_wdata;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (wb_valid) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic             wb_valid;
  logic             wb_regwrite;
  logic [1:0]       wb_wdsel;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_alu_result;
  logic [XLEN-1:0]  wb_mem_data;
  logic [XLEN-1:0]  wb_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [XLEN-1:0]  id_rd1;
  logic [XLEN-1:0]  id_rd2;
  logic [4:0]       dbg_addr;
  logic [XLEN-1:0]  dbg_data;
  logic [XLEN-1:0]  wb_wdata;
  logic             wb_we;
  logic [CNT_W-1:0] instret;

  wb_regfile #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb_valid      (wb_valid),
    .wb_regwrite   (wb_regwrite),
    .wb_wdsel      (wb_wdsel),
    .wb_rd         (wb_rd),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .wb_pc         (wb_pc),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd1        (id_rd1),
    .id_rd2        (id_rd2),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .wb_wdata      (wb_wdata),
    .wb_we         (wb_we),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [XLEN-1:0]  exp_q [$];
  logic [XLEN-1:0]  mregs [32];
  logic [CNT_W-1:0] m_instret;
  logic [XLEN-1:0]  m_dbg;

  function automatic logic [XLEN-1:0] model_wdata(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                                  input logic [XLEN-1:0] mem, input logic [XLEN-1:0] pc);
    if (sel == 2'b00) return alu;
    if (sel == 2'b01) return mem;
    if (sel == 2'b10) return pc + 32'd4;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_instret = '0;
    m_dbg     = '0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem, input logic [XLEN-1:0] pc);
    wb_valid      = v;
    wb_regwrite   = rw;
    wb_wdsel      = sel;
    wb_rd         = rd;
    wb_alu_result = alu;
    wb_mem_data   = mem;
    wb_pc         = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 5'd0, '0, '0, '0);
  endtask

  // Advance the model over the coming rising edge, then settle at the next falling edge.
  task automatic step();
    logic [XLEN-1:0] wd;
    wd    = model_wdata(wb_wdsel, wb_alu_result, wb_mem_data, wb_pc);
    m_dbg = (dbg_addr == 5'd0) ? '0 : mregs[dbg_addr];
    if (wb_valid) m_instret = m_instret + 1'b1;
    if (wb_valid && wb_regwrite && wb_rd != 5'd0) mregs[wb_rd] = wd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] e;
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_1234, '0, '0);
    id_rs1   = 5'd5;
    dbg_addr = 5'd5;
    step();
    bubble();
    step();
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0000_1234);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL reset_pre_rd1 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL reset_pre_dbg got=%h exp=%h", dbg_data, e); else passed++;
    #1 rstn = 1'b0;
    model_reset();
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL reset_rd1 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(instret) !== e) $display("FAIL reset_instret got=%h exp=%h", instret, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL reset_dbg got=%h exp=%h", dbg_data, e); else passed++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_alu_bypass();
    logic [XLEN-1:0] e;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 32'hDEAD_BEEF, '0, '0);
    id_rs1 = 5'd3;
    id_rs2 = 5'd3;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL bypass_rd1 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (id_rd2 !== e) $display("FAIL bypass_rd2 got=%h exp=%h", id_rd2, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(wb_we) !== e) $display("FAIL bypass_we got=%h exp=%h", wb_we, e); else passed++;
    step();
    bubble();
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL committed_rd1 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (id_rd2 !== e) $display("FAIL committed_rd2 got=%h exp=%h", id_rd2, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(instret) !== e) $display("FAIL instret_one got=%h exp=%h", instret, e); else passed++;
  endtask

  task automatic test_select();
    logic [XLEN-1:0] e;
    logic [1:0]      sel_t [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    logic [4:0]      rd_t  [5] = '{5'd4, 5'd1, 5'd2, 5'd6, 5'd6};
    logic [XLEN-1:0] alu_t [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0066, 32'h0000_0099};
    logic [XLEN-1:0] mem_t [5] = '{32'h0000_00FF, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    logic [XLEN-1:0] pc_t  [5] = '{32'h0000_0040, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0080, 32'h0000_0090};
    logic [XLEN-1:0] res_t [5] = '{32'h0000_00FF, 32'h0000_1004, 32'h0000_0000, 32'h0000_0066, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, sel_t[i], rd_t[i], alu_t[i], mem_t[i], pc_t[i]);
      id_rs1 = 5'd0;
      id_rs2 = 5'd0;
      exp_q.push_back(res_t[i]);
      #1;
      e = exp_q.pop_front(); total++;
      if (wb_wdata !== e) $display("FAIL sel_wdata[%0d] got=%h exp=%h", i, wb_wdata, e); else passed++;
      step();
      bubble();
      id_rs1 = rd_t[i];
      exp_q.push_back(res_t[i]);
      #1;
      e = exp_q.pop_front(); total++;
      if (id_rd1 !== e) $display("FAIL sel_commit[%0d] got=%h exp=%h", i, id_rd1, e); else passed++;
    end
  endtask

  task automatic test_x0();
    logic [XLEN-1:0] e;
    drive(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0055, '0, '0);
    id_rs1 = 5'd0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL x0_rd1 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(wb_we) !== e) $display("FAIL x0_we got=%h exp=%h", wb_we, e); else passed++;
    step();
    bubble();
    exp_q.push_back(XLEN'(m_instret));
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (XLEN'(instret) !== e) $display("FAIL x0_instret got=%h exp=%h", instret, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL x0_after got=%h exp=%h", id_rd1, e); else passed++;
  endtask

  task automatic test_bubble();
    logic [XLEN-1:0] e;
    logic [CNT_W-1:0] cnt_before;
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_0700, '0, '0);
    step();
    cnt_before = m_instret;
    drive(1'b0, 1'b1, 2'b00, 5'd7, 32'h0000_0077, '0, '0);
    id_rs1 = 5'd7;
    exp_q.push_back(32'h0000_0700);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL bubble_nobypass got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(wb_we) !== e) $display("FAIL bubble_we got=%h exp=%h", wb_we, e); else passed++;
    step();
    bubble();
    exp_q.push_back(32'h0000_0700);
    exp_q.push_back(XLEN'(cnt_before));
    #1;
    e = exp_q.pop_front(); total++;
    if (id_rd1 !== e) $display("FAIL bubble_x7 got=%h exp=%h", id_rd1, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (XLEN'(instret) !== e) $display("FAIL bubble_instret got=%h exp=%h", instret, e); else passed++;
  endtask

  task automatic test_counter_wrap();
    logic [XLEN-1:0] e;
    #2 rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 3) == 0, 2'b00, 5'd9, XLEN'(i), '0, '0);
      step();
      exp_q.push_back(XLEN'(m_instret));
      #1;
      e = exp_q.pop_front(); total++;
      if (XLEN'(instret) !== e) $display("FAIL wrap_count[%0d] got=%h exp=%h", i, instret, e); else passed++;
    end
    bubble();
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (XLEN'(instret) !== e) $display("FAIL wrap_zero got=%h exp=%h", instret, e); else passed++;
  endtask

  task automatic test_dbg();
    logic [XLEN-1:0] e;
    dbg_addr = 5'd3;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 32'hCAFE_0003, '0, '0);
    step();
    bubble();
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL dbg_precommit got=%h exp=%h", dbg_data, e); else passed++;
    step();
    exp_q.push_back(32'hCAFE_0003);
    exp_q.push_back(m_dbg);
    #1;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL dbg_commit got=%h exp=%h", dbg_data, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL dbg_model got=%h exp=%h", dbg_data, e); else passed++;
    dbg_addr = 5'd0;
    step();
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); total++;
    if (dbg_data !== e) $display("FAIL dbg_x0 got=%h exp=%h", dbg_data, e); else passed++;
  endtask

  initial begin
    rstn     = 1'b0;
    id_rs1   = 5'd0;
    id_rs2   = 5'd0;
    dbg_addr = 5'd0;
    bubble();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_alu_bypass();
    test_select();
    test_x0();
    test_bubble();
    test_counter_wrap();
    test_dbg();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
